dvp_capture: RTL and testbench

Camera-side capture front end for the OV5640 → SDRAM → VGA path. The block samples the sensor's 8-bit DVP bus (vsync, href, data) on the pixel clock and packs byte pairs into RGB565 words. It discards the first frames after reset while the sensor settles, then emits framed pixel words (valid, start-of-frame, end-of-frame) to the SDRAM write FIFO. The VGA driver later reads those words back out.

---
 rtl/dvp_capture_if.sv | 25 ++
 rtl/dvp_capture.sv | 157 +++++++++++++++
 tb/tb_dvp_capture.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_capture_if.sv
// DVP capture bus: camera-side inputs and framed RGB565 pixel outputs.
interface dvp_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        capture_en;
  logic [15:0] pixel_dout;
  logic        pixel_dout_vld;
  logic        pixel_sop;
  logic        pixel_eop;
  logic        frame_err;
  logic        capturing;

  // Sensor / test side drives the camera bus and watches the pixel stream
  modport master (
    output cam_vsync, cam_href, cam_data, capture_en,
    input  pixel_dout, pixel_dout_vld, pixel_sop, pixel_eop, frame_err, capturing
  );

  // Capture block consumes the camera bus and produces the pixel stream
  modport slave (
    input  cam_vsync, cam_href, cam_data, capture_en,
    output pixel_dout, pixel_dout_vld, pixel_sop, pixel_eop, frame_err, capturing
  );
endinterface

// File: rtl/dvp_capture.sv
// OV5640 DVP capture: registers the 8-bit camera bus, skips settling frames after reset,
// packs byte pairs into RGB565 words and flags malformed frames.
module dvp_capture #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned FRAME_SKIP = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  dvp_capture_if.slave  dvp
);

  // x must be able to reach H_ACTIVE+1 so an over-long line never looks exact
  localparam int unsigned XW = $clog2(H_ACTIVE + 2);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam int unsigned SW = $clog2(FRAME_SKIP + 2);

  localparam logic [XW-1:0] XEnd    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] XLast   = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] XSat    = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] YEnd    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] YLast   = YW'(V_ACTIVE - 1);
  localparam logic [SW-1:0] SkipEnd = SW'(FRAME_SKIP);

  typedef enum logic [1:0] {StSkip, StWaitVs, StCapture} state_e;

  logic          r_vsync, r_href, r_vsync_d, r_href_d;
  logic [7:0]    r_data;
  logic [SW-1:0] r_skip_cnt;
  state_e        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_tog;
  logic [7:0]    r_hi;
  logic          r_eop_seen;
  logic [15:0]   r_dout;
  logic          r_vld, r_sop, r_eop, r_err, r_capturing;

  logic w_vs_rise, w_vs_fall, w_hr_fall;
  logic w_in_cap, w_emit, w_eop_now, w_line_bad, w_vs_bad;

  assign w_vs_rise = r_vsync & ~r_vsync_d;
  assign w_vs_fall = ~r_vsync & r_vsync_d;
  assign w_hr_fall = ~r_href & r_href_d;

  assign w_in_cap   = (r_state == StCapture);
  assign w_emit     = w_in_cap & r_href & r_tog & (r_x < XEnd) & (r_y < YEnd);
  assign w_eop_now  = w_emit & (r_x == XLast) & (r_y == YLast);
  // Lines past V_ACTIVE are ignored, so only in-frame lines are checked
  assign w_line_bad = w_in_cap & w_hr_fall & (r_y < YEnd) & (r_tog | (r_x != XEnd));
  // A word completing alongside vsync counts towards frame completion
  assign w_vs_bad   = w_in_cap & w_vs_rise & ~(r_eop_seen | w_eop_now);

  // Input stage: register camera pins once and keep previous sync levels for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_data    <= 8'h00;
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync   <= dvp.cam_vsync;
      r_href    <= dvp.cam_href;
      r_data    <= dvp.cam_data;
      r_vsync_d <= r_vsync;
      r_href_d  <= r_href;
    end
  end

  // Count vsync pulses after reset, saturating at the number of frames to discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
    end else if (w_vs_rise && (r_skip_cnt != SkipEnd)) begin
      r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end

  // Frame FSM with byte packing, line checks and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StSkip;
      r_x         <= '0;
      r_y         <= '0;
      r_tog       <= 1'b0;
      r_hi        <= 8'h00;
      r_eop_seen  <= 1'b0;
      r_dout      <= 16'h0000;
      r_vld       <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_err       <= 1'b0;
      r_capturing <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      r_sop <= 1'b0;
      r_eop <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        StSkip: begin
          if (r_skip_cnt == SkipEnd) r_state <= StWaitVs;
        end
        StWaitVs: begin
          if (w_vs_fall && dvp.capture_en) begin
            r_state     <= StCapture;
            r_capturing <= 1'b1;
            r_x         <= '0;
            r_y         <= '0;
            r_tog       <= 1'b0;
            r_eop_seen  <= 1'b0;
          end
        end
        StCapture: begin
          if (r_href) begin
            r_tog <= ~r_tog;
            if (!r_tog) begin
              r_hi <= r_data;
            end else if (r_x != XSat) begin
              r_x <= r_x + 1'b1;
            end
          end
          if (w_emit) begin
            r_dout <= {r_hi, r_data};
            r_vld  <= 1'b1;
            r_sop  <= (r_x == '0) && (r_y == '0);
            r_eop  <= w_eop_now;
          end
          if (w_eop_now) r_eop_seen <= 1'b1;
          if (w_hr_fall) begin
            r_x   <= '0;
            r_tog <= 1'b0;
            if (r_y < YEnd) r_y <= r_y + 1'b1;
          end
          // Line-end fault and early vsync in one cycle still give a single pulse
          if (w_line_bad || w_vs_bad) r_err <= 1'b1;
          if (w_line_bad || w_vs_rise) begin
            r_state     <= StWaitVs;
            r_capturing <= 1'b0;
          end
        end
        default: begin
          r_state     <= StSkip;
          r_capturing <= 1'b0;
        end
      endcase
    end
  end

  assign dvp.pixel_dout     = r_dout;
  assign dvp.pixel_dout_vld = r_vld;
  assign dvp.pixel_sop      = r_sop;
  assign dvp.pixel_eop      = r_eop;
  assign dvp.frame_err      = r_err;
  assign dvp.capturing      = r_capturing;

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture: frame-level reference model feeds a scoreboard of expected
// words and error pulses (with their cycle stamps); a monitor pops and compares.
module tb_dvp_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dvp_capture_if bus ();

  dvp_capture #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .FRAME_SKIP(FS)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dvp  (bus)
  );

  typedef struct {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    int          cyc;
  } word_t;

  word_t       exp_q[$];
  int          err_q[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          cyc       = 0;
  logic [15:0] last_word = 16'h0;
  int          pc        = 0;   // vsync pulses seen since reset
  bit          next_capt = 1'b0; // whether the frame after the latest pulse is captured

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every strobe and error pulse against the scoreboard
  always @(negedge clk) begin : mon
    word_t e;
    if (!rst_n) begin
      last_word = 16'h0;
    end else begin
      if (bus.pixel_dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.pixel_dout_vld, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word_dout_sop_eop", {bus.pixel_dout, bus.pixel_sop, bus.pixel_eop},
              {e.d, e.sop, e.eop});
          chk("word_cycle", cyc, e.cyc);
        end
        last_word = bus.pixel_dout;
      end else begin
        chk("idle_hold_no_sop_eop", {bus.pixel_dout, bus.pixel_sop, bus.pixel_eop},
            {last_word, 2'b00});
      end
      if (bus.frame_err) begin
        if (err_q.size() == 0) chk("unexpected_frame_err", bus.frame_err, 0);
        else chk("frame_err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.cam_vsync = vs;
    bus.cam_href  = hr;
    bus.cam_data  = d;
  endtask

  // One frame: nl lines of the given byte counts followed by a 4-cycle vsync pulse.
  // vs_mode 0: vsync rises with the last byte; 1: with the last href fall; 2: after a gap.
  task automatic send_frame(input int nl, input int l0, input int l1, input int l2,
                            input int vs_mode, input bit next_en, input bit directed);
    int          lens[3];
    bit          capt, done, ferr, active, last, vs;
    int          y, vs_cyc, len;
    logic [7:0]  d, hi;
    word_t       w;
    lens[0] = l0;
    lens[1] = l1;
    lens[2] = l2;
    capt    = next_capt;
    y       = 0;
    done    = 1'b0;
    ferr    = 1'b0;
    hi      = 8'h0;
    vs_cyc  = 0;
    for (int j = 0; j < nl; j++) begin
      len    = lens[j];
      last   = (j == nl - 1);
      active = capt && !ferr && (y < V);
      for (int b = 0; b < len; b++) begin
        d = 8'($urandom);
        if (directed && j == 0 && b == 0) d = 8'hF8;
        if (directed && j == 0 && b == 1) d = 8'h1F;
        vs = last && (b == len - 1) && (vs_mode == 0);
        tick(vs, 1'b1, d);
        if (vs) vs_cyc = cyc;
        if (b % 2 == 0) begin
          hi = d;
        end else if (active && (b / 2) < H) begin
          w.d   = {hi, d};
          w.sop = (b / 2 == 0) && (y == 0);
          w.eop = (b / 2 == H - 1) && (y == V - 1);
          w.cyc = cyc + 2;
          exp_q.push_back(w);
          if (w.eop) done = 1'b1;
        end
      end
      if (!(last && vs_mode == 0)) begin
        vs = last && (vs_mode == 1);
        tick(vs, 1'b0, 8'h0);
        if (vs) vs_cyc = cyc;
        if (active && ((len % 2) != 0 || (len / 2) != H)) begin
          err_q.push_back(cyc + 2);
          ferr = 1'b1;
        end else if (active) begin
          y++;
        end
        if (!vs) begin
          tick(1'b0, 1'b0, 8'h0);
          tick(1'b0, 1'b0, 8'h0);
          if (last) begin
            #3;
            chk("capturing_before_vsync", bus.capturing, capt && !ferr);
            tick(1'b1, 1'b0, 8'h0);
            vs_cyc = cyc;
          end
        end
      end
      // Toggling enable mid-frame must not disturb the frame in flight
      if (j == 0) bus.capture_en = 1'($urandom_range(0, 1));
    end
    bus.capture_en = next_en;
    if (capt && !ferr && !done) err_q.push_back(vs_cyc + 2);
    repeat (3) tick(1'b1, 1'b0, 8'h0);
    repeat (3) tick(1'b0, 1'b0, 8'h0);
    pc++;
    next_capt = (pc >= FS) && next_en;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d, hi;
    word_t      w;
    bus.cam_vsync  = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_data   = 8'h0;
    bus.capture_en = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_dout", bus.pixel_dout, 0);
    chk("reset_vld", bus.pixel_dout_vld, 0);
    chk("reset_sop", bus.pixel_sop, 0);
    chk("reset_eop", bus.pixel_eop, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_capturing", bus.capturing, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Two settling frames are discarded, the third is captured
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b1);

    // Malformed frames and simultaneous-event cases
    send_frame(2, 8, 6, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 9, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 10, 8, 0, 2, 1'b1, 1'b0);
    send_frame(1, 8, 0, 0, 2, 1'b0, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 0, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 1, 1'b1, 1'b0);
    send_frame(2, 8, 6, 0, 1, 1'b1, 1'b0);

    // Random frame mix
    for (int f = 0; f < 40; f++) begin
      int kind, mode;
      bit en;
      kind = $urandom_range(0, 6);
      mode = $urandom_range(0, 2);
      en   = ($urandom_range(0, 3) != 0) || (f == 39);
      case (kind)
        0:       send_frame(2, 8, 8, 0, mode, en, 1'b0);
        1:       send_frame(2, 8, 6, 0, mode, en, 1'b0);
        2:       send_frame(2, 9, 8, 0, mode, en, 1'b0);
        3:       send_frame(2, 10, 8, 0, mode, en, 1'b0);
        4:       send_frame(1, 8, 0, 0, mode, en, 1'b0);
        5:       send_frame(3, 8, 8, 8, mode, en, 1'b0);
        default: send_frame(2, 2, 8, 0, mode, en, 1'b0);
      endcase
    end

    // Reset in the middle of line 0 of a captured frame
    hi = 8'h0;
    for (int b = 0; b < 5; b++) begin
      d = 8'($urandom);
      tick(1'b0, 1'b1, d);
      if (b % 2 == 0) begin
        hi = d;
      end else begin
        w.d   = {hi, d};
        w.sop = (b == 1);
        w.eop = 1'b0;
        w.cyc = cyc + 2;
        exp_q.push_back(w);
      end
    end
    @(posedge clk);
    #7;
    chk("capturing_pre_reset", bus.capturing, 1);
    chk("vld_pre_reset", bus.pixel_dout_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", bus.pixel_dout, 0);
    chk("midreset_vld", bus.pixel_dout_vld, 0);
    chk("midreset_sop", bus.pixel_sop, 0);
    chk("midreset_eop", bus.pixel_eop, 0);
    chk("midreset_frame_err", bus.frame_err, 0);
    chk("midreset_capturing", bus.capturing, 0);
    bus.cam_vsync  = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_data   = 8'h0;
    bus.capture_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    pc        = 0;
    next_capt = 1'b0;

    // Skipping restarts after reset
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b0);
    send_frame(2, 8, 8, 0, 2, 1'b1, 1'b1);

    repeat (10) tick(1'b0, 1'b0, 8'h0);
    chk("words_left_in_scoreboard", exp_q.size(), 0);
    chk("errs_left_in_scoreboard", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
